// File: rtl/framebuffer_uart_tx.sv
// framebuffer_uart_tx: streams the display framebuffer to the host over the UART
// transmit path, optionally preceded by a frame-start sync byte.
//
// Ports:
//   clk                   system clock
//   rst                   asynchronous active-low reset
//   start                 one-cycle request to begin a dump (ignored while busy or in the done cycle)
//   busy                  high from the cycle after an accepted start until done
//   done                  one-cycle pulse once the last byte has left the uart
//   mem_read / mem_addr   one-cycle framebuffer read request and byte index
//   mem_data              framebuffer read data, qualified by mem_data_ready
//   mem_data_ready        read data valid, one or more cycles after mem_read
//   uart_transmit         one-cycle pulse starting a uart byte
//   uart_tx_byte          byte for the uart, held until the byte completes
//   uart_is_transmitting  high while the uart shifts a byte out
module framebuffer_uart_tx #(
    parameter int unsigned DISPLAY_SIZE = 1024,
    parameter bit          SEND_SYNC    = 1'b1,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       mem_read,
    output logic [9:0] mem_addr,
    input  logic [7:0] mem_data,
    input  logic       mem_data_ready,
    output logic       uart_transmit,
    output logic [7:0] uart_tx_byte,
    input  logic       uart_is_transmitting
);

    localparam int unsigned ADDR_W = 10;
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DISPLAY_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        FETCH,
        WAIT_DATA,
        SEND,
        TX_START,
        TX_WAIT,
        FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              after_sync_q, after_sync_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              transmit_q, transmit_d;
    logic [7:0]        tx_byte_q, tx_byte_d;

    // Next-state and registered-output logic. mem_read/mem_addr are set on the
    // transition into FETCH so the read request coincides with the FETCH cycle.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        after_sync_d = after_sync_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        mem_read_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        transmit_d   = 1'b0;
        tx_byte_d    = tx_byte_q;

        unique case (state_q)
            IDLE: begin
                // done_q high means this is the done cycle: a start here is dropped.
                if (start && !done_q) begin
                    busy_d  = 1'b1;
                    index_d = '0;
                    if (SEND_SYNC) begin
                        state_d = SYNC;
                    end else begin
                        state_d    = FETCH;
                        mem_read_d = 1'b1;
                        mem_addr_d = '0;
                    end
                end
            end
            SYNC: begin
                tx_byte_d    = SYNC_BYTE;
                transmit_d   = 1'b1;
                after_sync_d = 1'b1;
                state_d      = TX_START;
            end
            FETCH: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (mem_data_ready) begin
                    tx_byte_d = mem_data;
                    state_d   = SEND;
                end
            end
            SEND: begin
                transmit_d   = 1'b1;
                after_sync_d = 1'b0;
                state_d      = TX_START;
            end
            TX_START: begin
                // uart_is_transmitting only rises the cycle after the pulse.
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (!uart_is_transmitting) begin
                    if (after_sync_q) begin
                        after_sync_d = 1'b0;
                        state_d      = FETCH;
                        mem_read_d   = 1'b1;
                        mem_addr_d   = index_q;
                    end else if (index_q == LAST_INDEX) begin
                        state_d = FINISH;
                    end else begin
                        index_d    = index_q + ADDR_W'(1);
                        state_d    = FETCH;
                        mem_read_d = 1'b1;
                        mem_addr_d = index_q + ADDR_W'(1);
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                index_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            index_q      <= '0;
            after_sync_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            transmit_q   <= 1'b0;
            tx_byte_q    <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            after_sync_q <= after_sync_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mem_read_q   <= mem_read_d;
            mem_addr_q   <= mem_addr_d;
            transmit_q   <= transmit_d;
            tx_byte_q    <= tx_byte_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_read      = mem_read_q;
    assign mem_addr      = mem_addr_q;
    assign uart_transmit = transmit_q;
    assign uart_tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_framebuffer_uart_tx.sv
// Bench for framebuffer_uart_tx: a 1024-byte dump with sync byte (dut_a) and an
// 8-byte dump without sync (dut_b), each with its own memory and uart models.
// Expected bytes are queued by the stimulus; monitors pop them on uart_transmit.
module tb_framebuffer_uart_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // dut_a: DISPLAY_SIZE=1024, SEND_SYNC=1
    logic       start_a, busy_a, done_a, mem_read_a, mem_rdy_a, tx_a;
    logic [9:0] mem_addr_a;
    logic [7:0] mem_data_a, txb_a;
    logic       istx_a = 1'b0;
    // dut_b: DISPLAY_SIZE=8, SEND_SYNC=0
    logic       start_b, busy_b, done_b, mem_read_b, mem_rdy_b, tx_b;
    logic [9:0] mem_addr_b;
    logic [7:0] mem_data_b, txb_b;
    logic       istx_b = 1'b0;

    framebuffer_uart_tx #(.DISPLAY_SIZE(1024), .SEND_SYNC(1'b1), .SYNC_BYTE(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_read(mem_read_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
        .mem_data_ready(mem_rdy_a), .uart_transmit(tx_a), .uart_tx_byte(txb_a),
        .uart_is_transmitting(istx_a)
    );

    framebuffer_uart_tx #(.DISPLAY_SIZE(8), .SEND_SYNC(1'b0), .SYNC_BYTE(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_read(mem_read_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
        .mem_data_ready(mem_rdy_b), .uart_transmit(tx_b), .uart_tx_byte(txb_b),
        .uart_is_transmitting(istx_b)
    );

    // Model controls driven by the stimulus process.
    int lat_a = 1, lat_b = 1, hold_a = 10, hold_b = 10;
    bit stray_b = 1'b0, long_b = 1'b0, mode_b = 1'b0;

    // Scoreboards and counters.
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int checks_s = 0, err_s = 0, checks_a = 0, err_a = 0, checks_b = 0, err_b = 0;
    int pulses_a = 0, dones_a = 0, reads_a = 0;
    int pulses_b = 0, dones_b = 0, reads_b = 0;

    // Memory model a: mem[i] = i[7:0], ready lat_a cycles after mem_read.
    logic       pend_a;
    int         cnt_a;
    logic [9:0] addr_l_a;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rdy_a <= 1'b0; pend_a <= 1'b0; cnt_a <= 0; addr_l_a <= '0; mem_data_a <= '0;
        end else begin
            mem_rdy_a <= 1'b0;
            if (mem_read_a) begin
                if (lat_a <= 1) begin
                    mem_rdy_a <= 1'b1; mem_data_a <= mem_addr_a[7:0];
                end else begin
                    pend_a <= 1'b1; cnt_a <= lat_a - 1; addr_l_a <= mem_addr_a;
                end
            end else if (pend_a) begin
                if (cnt_a <= 1) begin
                    mem_rdy_a <= 1'b1; mem_data_a <= addr_l_a[7:0]; pend_a <= 1'b0;
                end else begin
                    cnt_a <= cnt_a - 1;
                end
            end
        end
    end

    // Memory model b: 3C everywhere (mode 0) or 7*i+3 (mode 1); optional stray ready.
    logic       pend_b;
    int         cnt_b, ucnt_b, ucnt_a, upc_b;
    logic [9:0] addr_l_b;
    function automatic logic [7:0] mem_b_val(input logic [9:0] a, input bit m);
        logic [7:0] v;
        v = m ? 8'(a * 10'd7 + 10'd3) : 8'h3C;
        return v;
    endfunction
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rdy_b <= 1'b0; pend_b <= 1'b0; cnt_b <= 0; addr_l_b <= '0; mem_data_b <= '0;
        end else begin
            mem_rdy_b <= 1'b0;
            if (mem_read_b) begin
                if (lat_b <= 1) begin
                    mem_rdy_b <= 1'b1; mem_data_b <= mem_b_val(mem_addr_b, mode_b);
                end else begin
                    pend_b <= 1'b1; cnt_b <= lat_b - 1; addr_l_b <= mem_addr_b;
                end
            end else if (pend_b) begin
                if (cnt_b <= 1) begin
                    mem_rdy_b <= 1'b1; mem_data_b <= mem_b_val(addr_l_b, mode_b); pend_b <= 1'b0;
                end else begin
                    cnt_b <= cnt_b - 1;
                end
            end else if (stray_b && istx_b && ucnt_b == 4) begin
                mem_rdy_b <= 1'b1; mem_data_b <= 8'hEE;
            end
        end
    end

    // Uart models: busy for hold cycles starting the cycle after the pulse; not reset by rst.
    initial begin ucnt_a = 0; ucnt_b = 0; upc_b = 0; end
    always @(posedge clk) begin
        if (tx_a) begin
            istx_a <= 1'b1; ucnt_a <= hold_a;
        end else if (istx_a) begin
            if (ucnt_a <= 1) istx_a <= 1'b0;
            else ucnt_a <= ucnt_a - 1;
        end
    end
    always @(posedge clk) begin
        if (tx_b) begin
            istx_b <= 1'b1; ucnt_b <= (long_b && upc_b == 3) ? 2000 : hold_b; upc_b <= upc_b + 1;
        end else if (istx_b) begin
            if (ucnt_b <= 1) istx_b <= 1'b0;
            else ucnt_b <= ucnt_b - 1;
        end
    end

    // Monitor a: scoreboard pop on each pulse, no pulse during a transmission,
    // byte stable while the uart is shifting.
    logic [7:0] held_a, held_b;
    bit         hv_a = 1'b0, hv_b = 1'b0;
    always @(negedge clk) begin
        if (tx_a) begin
            pulses_a++;
            checks_a++;
            if (istx_a) begin err_a++; $display("FAIL overlap_a: pulse while transmitting, byte %h", txb_a); end
            checks_a++;
            if (q_a.size() == 0) begin
                err_a++; $display("FAIL byte_a: unexpected byte %h, none required", txb_a);
            end else begin
                logic [7:0] e;
                e = q_a.pop_front();
                if (txb_a !== e) begin err_a++; $display("FAIL byte_a #%0d: got %h, required %h", pulses_a, txb_a, e); end
            end
            held_a = txb_a; hv_a = 1'b1;
        end else if (hv_a && rst) begin
            if (istx_a) begin
                checks_a++;
                if (txb_a !== held_a) begin err_a++; $display("FAIL stable_a: got %h, required %h", txb_a, held_a); end
            end else hv_a = 1'b0;
        end
        if (!rst) hv_a = 1'b0;
        if (done_a) dones_a++;
        if (mem_read_a) reads_a++;
    end

    always @(negedge clk) begin
        if (tx_b) begin
            pulses_b++;
            checks_b++;
            if (istx_b) begin err_b++; $display("FAIL overlap_b: pulse while transmitting, byte %h", txb_b); end
            checks_b++;
            if (q_b.size() == 0) begin
                err_b++; $display("FAIL byte_b: unexpected byte %h, none required", txb_b);
            end else begin
                logic [7:0] e;
                e = q_b.pop_front();
                if (txb_b !== e) begin err_b++; $display("FAIL byte_b #%0d: got %h, required %h", pulses_b, txb_b, e); end
            end
            held_b = txb_b; hv_b = 1'b1;
        end else if (hv_b && rst) begin
            if (istx_b) begin
                checks_b++;
                if (txb_b !== held_b) begin err_b++; $display("FAIL stable_b: got %h, required %h", txb_b, held_b); end
            end else hv_b = 1'b0;
        end
        if (!rst) hv_b = 1'b0;
        if (done_b) dones_b++;
        if (mem_read_b) reads_b++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks_s++;
        if (act != exp) begin
            err_s++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_dump_a();
        q_a.push_back(8'hA5);
        for (int i = 0; i < 1024; i++) q_a.push_back(8'(i));
    endtask

    // Pulse start on one dut and return edges until its first uart_transmit.
    task automatic start_and_latency(input bit on_b, output int lat);
        if (on_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        lat = 1;
        while (!(on_b ? tx_b : tx_a) && lat < 50) begin tick(); lat++; end
    endtask

    task automatic wait_done(input bit on_b, input int budget, input string name);
        int t = 0;
        while (!(on_b ? done_b : done_a) && t < budget) begin tick(); t++; end
        check({name, "_done_timeout"}, int'(t < budget), 1);
    endtask

    task automatic wait_pulses_a(input int n, input int budget, input string name);
        int t = 0;
        while (pulses_a < n && t < budget) begin tick(); t++; end
        check({name, "_pulse_timeout"}, int'(t < budget), 1);
    endtask

    task automatic reset_check_a(input string name);
        #2 rst = 1'b0;
        #1;
        check({name, "_busy"}, int'(busy_a), 0);
        check({name, "_mem_read"}, int'(mem_read_a), 0);
        check({name, "_transmit"}, int'(tx_a), 0);
        check({name, "_tx_byte"}, int'(txb_a), 0);
        check({name, "_mem_addr"}, int'(mem_addr_a), 0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int lat, p0, d0, r0, t;
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        #12;
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_done_a", int'(done_a), 0);
        check("rst_mem_read_a", int'(mem_read_a), 0);
        check("rst_mem_addr_a", int'(mem_addr_a), 0);
        check("rst_transmit_a", int'(tx_a), 0);
        check("rst_tx_byte_a", int'(txb_a), 0);
        check("rst_busy_b", int'(busy_b), 0);
        check("rst_transmit_b", int'(tx_b), 0);
        tick();
        rst = 1'b1;
        tick();

        // Full dump with sync byte, 10-cycle uart.
        push_dump_a();
        start_and_latency(1'b0, lat);
        check("latency_sync", lat, 2);
        check("busy_during_dump", int'(busy_a), 1);
        wait_done(1'b0, 30000, "dump1");
        tick(); tick();
        check("dump1_pulses", pulses_a, 1025);
        check("dump1_dones", dones_a, 1);
        check("dump1_busy_after", int'(busy_a), 0);
        check("dump1_queue_left", q_a.size(), 0);

        // No sync, all 3C, one byte held 2000 cycles by the uart.
        long_b = 1'b1;
        for (int i = 0; i < 8; i++) q_b.push_back(8'h3C);
        start_and_latency(1'b1, lat);
        check("latency_nosync", lat, 4);
        wait_done(1'b1, 5000, "dump_b1");
        tick();
        long_b = 1'b0;
        check("b1_pulses", pulses_b, 8);
        check("b1_reads", reads_b, 8);
        check("b1_dones", dones_b, 1);
        check("b1_queue_left", q_b.size(), 0);

        // Slow memory plus stray ready pulses during transmission.
        mode_b = 1'b1; lat_b = 5; stray_b = 1'b1;
        p0 = pulses_b; r0 = reads_b;
        q_b.push_back(8'h03); q_b.push_back(8'h0A); q_b.push_back(8'h11); q_b.push_back(8'h18);
        q_b.push_back(8'h1F); q_b.push_back(8'h26); q_b.push_back(8'h2D); q_b.push_back(8'h34);
        start_and_latency(1'b1, lat);
        wait_done(1'b1, 5000, "dump_b2");
        tick();
        stray_b = 1'b0;
        check("b2_pulses", pulses_b - p0, 8);
        check("b2_reads", reads_b - r0, 8);
        check("b2_queue_left", q_b.size(), 0);

        // Starts at byte 100 and in the done cycle are dropped; one cycle later is taken.
        hold_a = 3;
        p0 = pulses_a; d0 = dones_a;
        push_dump_a();
        start_and_latency(1'b0, lat);
        wait_pulses_a(p0 + 102, 5000, "byte100");
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("busy_after_midstart", int'(busy_a), 1);
        wait_done(1'b0, 20000, "dump2");
        check("dump2_pulses", pulses_a - p0, 1025);
        check("dump2_queue_left", q_a.size(), 0);
        check("dump2_dones", dones_a - d0, 1);
        push_dump_a();
        start_a = 1'b1;
        tick();
        check("done_cycle_start_ignored", int'(busy_a), 0);
        tick();
        start_a = 1'b0;
        check("next_cycle_start_taken", int'(busy_a), 1);
        wait_done(1'b0, 20000, "dump3");
        tick();
        check("dump23_pulses", pulses_a - p0, 2050);
        check("dump23_dones", dones_a - d0, 2);
        check("dump3_queue_left", q_a.size(), 0);

        // Reset while the uart is sending byte 37.
        p0 = pulses_a;
        q_a.push_back(8'hA5);
        for (int i = 0; i <= 37; i++) q_a.push_back(8'(i));
        start_and_latency(1'b0, lat);
        wait_pulses_a(p0 + 39, 5000, "byte37");
        t = 0;
        while (!istx_a && t < 10) begin tick(); t++; end
        reset_check_a("abort37");
        t = 0;
        while (istx_a && t < 100) begin tick(); t++; end
        check("abort37_queue_left", q_a.size(), 0);
        check("abort37_no_done", dones_a - d0, 2);

        // Restart after reset begins again with the sync byte and index 0.
        p0 = pulses_a;
        q_a.push_back(8'hA5);
        for (int i = 0; i < 5; i++) q_a.push_back(8'(i));
        start_and_latency(1'b0, lat);
        check("restart_latency", lat, 2);
        wait_pulses_a(p0 + 6, 500, "restart");
        reset_check_a("abort_restart");
        check("restart_queue_left", q_a.size(), 0);
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks_s + checks_a + checks_b, err_s + err_a + err_b);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/framebuffer_uart_tx.md
Name: framebuffer_uart_tx

Overview:
- Dumps the 128x8-page (1024-byte) display framebuffer back to the host over the UART transmit path. This is the readback counterpart of the UART-to-framebuffer receive path.
- On a start pulse it sends an optional sync byte. It then fetches bytes 0..DISPLAY_SIZE-1 in order through a request/ready read port and hands each byte to the uart transmitter using its transmit/is_transmitting handshake.
- It sits between the framebuffer memory and uart0's tx side in the top-level demo.

Parameters:
- DISPLAY_SIZE, 1024: number of bytes per dump; must be a power of two, at most 1024.
- SEND_SYNC, 1: when 1, send SYNC_BYTE before the framebuffer data; when 0, skip it.
- SYNC_BYTE, 8'hA5: frame-start marker value.

Ports:
- clk  input  1  system clock (12 MHz).
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- start  input  1  one-cycle request to begin a dump.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the last byte's transmission has finished.
- mem_read  output  1  one-cycle read request to the framebuffer.
- mem_addr  output  10  byte index being read.
- mem_data  input  8  read data.
- mem_data_ready  input  1  read data valid; arrives one or more cycles after mem_read.
- uart_transmit  output  1  one-cycle pulse to start a byte transmission.
- uart_tx_byte  output  8  byte to transmit; held stable from the pulse until the byte completes.
- uart_is_transmitting  input  1  high while the uart shifts a byte out.

Behaviour:
- Reset (rst=0, async): state=IDLE, index=0. All outputs are 0: busy, done, mem_read, mem_addr, uart_transmit, uart_tx_byte.
- States: IDLE, SYNC, FETCH, WAIT_DATA, SEND, TX_START, TX_WAIT, FINISH.
- IDLE
  - start=1: busy<=1, index<=0.
  - Next state is SYNC if SEND_SYNC=1, otherwise FETCH.
  - start while busy is ignored, not queued.
- SYNC: uart_tx_byte<=SYNC_BYTE, uart_transmit<=1 for one cycle, then TX_START. The return target after TX_WAIT is FETCH.
- FETCH: mem_addr<=index, mem_read<=1 for exactly one cycle, then WAIT_DATA.
- WAIT_DATA
  - Waits indefinitely for mem_data_ready=1, then latches uart_tx_byte<=mem_data and goes to SEND.
  - mem_data_ready while not in WAIT_DATA is ignored.
- SEND: uart_transmit<=1 for one cycle, then TX_START.
- TX_START: one-cycle guard, because uart_is_transmitting rises the cycle after the transmit pulse. Go to TX_WAIT.
- TX_WAIT: stay while uart_is_transmitting=1. On 0:
  - after the sync byte, go to FETCH;
  - after a data byte with index==DISPLAY_SIZE-1, go to FINISH;
  - otherwise index<=index+1, then FETCH.
- FINISH: done<=1 for one cycle, busy<=0, index<=0, then IDLE.
- Back-to-back dumps: start in the same cycle that done is high is ignored. Start one cycle later is accepted.
- Counting and latency:
  - index is 10 bits; it never wraps mid-dump.
  - Total uart_transmit pulses per dump = DISPLAY_SIZE + SEND_SYNC.
  - Latency from start to the first uart_transmit is 2 cycles with SEND_SYNC=1, and 4 cycles with SEND_SYNC=0 when mem_data_ready returns one cycle after mem_read.
- Reset mid-dump: immediate abort to IDLE with outputs cleared. A byte already handed to the uart may still finish; the block does not wait for it.
- uart_tx_byte is never changed while uart_is_transmitting=1.

Test Plan:
- Fill the memory model with mem[i]=i[7:0], SEND_SYNC=1, pulse start, uart model busy 10 cycles per byte -> 1025 bytes captured: A5, 00, 01, ..., FF repeated 4 times; exactly one done pulse; busy low afterwards.
- SEND_SYNC=0, DISPLAY_SIZE=8, mem = 8'h3C for all i -> exactly 8 uart_transmit pulses, all 3C; first pulse 4 cycles after start with a 1-cycle memory model.
- Memory model delays mem_data_ready by 5 cycles and adds a stray ready pulse during TX_WAIT -> captured sequence still equals mem[0..N-1] with no duplicate or skipped byte; mem_read pulses = N.
- Start pulsed again at byte 100 of a dump, and again in the done cycle -> both ignored; one done pulse and 1025 bytes total. Start one cycle after done -> a second full dump.
- rst driven to 0 while waiting at byte 37 -> busy, mem_read and uart_transmit drop to 0 asynchronously. A new start after release sends from SYNC_BYTE and index 0.
- Uart model holds uart_is_transmitting high for 2000 cycles on one byte -> no new uart_transmit and uart_tx_byte unchanged until it falls.
